cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among result producers: source 0 is the scalar ALU behind the reservation station, source 1 is the load/store buffer, and further sources are optional.
- Producers emit one-cycle result pulses and accept no backpressure, so each source gets a small FIFO.
- A round-robin arbiter picks one result per cycle and broadcasts it on a registered CDB to the ROB, RS and LSB.
- Exposes per-source almost-full so dispatch stalls before any loss.

Parameters:
- NUM_SRC, 2, number of producers (2..4).
- FIFO_DEPTH_BIT, 2, log2 of per-source FIFO depth (DEPTH = 4).
- ROB_WIDTH_BIT, `ROB_WIDTH_BIT, width of a ROB tag.
- SRC_BIT, derived localparam = max(1, clog2(NUM_SRC)), width of the source index.

Ports:
- clk_in  input  1  clock; all state updates on its rising edge.
- rst_in  input  1  asynchronous active-low reset.
- rdy_in  input  1  global pause; low freezes all state.
- flush  input  1  mispredict flush.
- src_valid  input  NUM_SRC  per-source result pulse.
- src_rob_id  input  NUM_SRC*ROB_WIDTH_BIT  tags, source k in slice k.
- src_value  input  NUM_SRC*32  values, source k in slice k.
- src_full  output  NUM_SRC  almost-full per source; dispatch to that unit stalls.
- cdb_valid  output  1  broadcast valid.
- cdb_rob_id  output  ROB_WIDTH_BIT  broadcast tag.
- cdb_value  output  32  broadcast value.
- cdb_src  output  SRC_BIT  granted source index.
- overflow_err  output  1  sticky; set when a push hits a full FIFO.

Behaviour:
- Reset (rst_in low, asynchronous):
  - All FIFOs empty; rr_ptr = 0.
  - cdb_valid = 0, cdb_rob_id = 0, cdb_value = 0, cdb_src = 0.
  - overflow_err = 0, src_full = 0.
  - Reset asserted mid-operation discards everything immediately.
- rdy_in low: no push, no pop, outputs and rr_ptr hold. Inputs in that cycle are ignored; producers are frozen too.
- Push: src_valid[k] in cycle t writes {rob_id, value} to FIFO k at edge t.
- Eligibility: source k is eligible in cycle t if FIFO k is non-empty.
- Grant: the first eligible source scanning rr_ptr, rr_ptr+1, … mod NUM_SRC.
  - The granted head is popped at edge t.
  - cdb_valid/rob_id/value/src are loaded at edge t and visible in t+1.
  - rr_ptr <= (grant+1) mod NUM_SRC.
  - No eligible source: cdb_valid <= 0 and rr_ptr holds.
- Latency: input pulse to CDB is 2 cycles minimum. Throughput is 1 result/cycle total.
- Per-source order is FIFO; there is no ordering guarantee across sources.
- src_full[k] = (count_k >= DEPTH-1). One slot of slack covers the producer's one-cycle reaction.
- Simultaneous push and pop on one FIFO:
  - The count is unchanged.
  - At count == DEPTH this is accepted, because the pop frees the slot.
- Push with count == DEPTH and no pop of that FIFO: data dropped, overflow_err <= 1 until reset.
- Flush (with rdy_in high) has priority over all other actions:
  - All FIFOs are cleared and cdb_valid <= 0 at that edge.
  - Pushes in the flush cycle are dropped; rr_ptr holds.
  - The CDB value registered before the flush is still visible during the flush cycle.
- Wrap-around: FIFO pointers are FIFO_DEPTH_BIT wide and wrap modulo DEPTH. count is FIFO_DEPTH_BIT+1 wide.

Optional Feature:
- Macro: CDB_BYPASS_EN.
- When defined:
  - A source whose FIFO is empty and whose src_valid is high is eligible in the same cycle.
  - If granted, its input goes straight to the CDB register (not written to the FIFO), giving latency 1.
  - If not granted, it is pushed normally.
  - Flush still drops it.
- When undefined: latency is exactly as above, with no combinational input-to-grant path.

Decomposition:
- const.v (shared package) gains:
  - CDB_SRC_ALU = 0, CDB_SRC_LSB = 1.
  - CDB_FIFO_DEPTH_BIT default.
  - Reuses existing ROB_WIDTH_BIT.
- Natural sub-module: cdb_src_fifo, one instance per source.
  - Ports: push, pop, flush, data in/out, count, empty, full.
  - The round-robin grant and output register stay in cdb_arbiter.

Test Plan:
- After reset, src_valid[0] with tag 3, value 0x11 in cycle 5 -> cdb_valid=1, tag 3, value 0x11, cdb_src=0 in cycle 7 only. With CDB_BYPASS_EN: cycle 6.
- Both sources push every cycle for 4 cycles, tags 0-3 on src0 and 8-11 on src1 -> CDB alternates src0, src1, src0, … (0, 8, 1, 9, …) with no bubbles; all 8 delivered.
- src1 pushes 3 entries while src0 keeps pushing -> src_full[1]=1 once count reaches 3. A 5th push while count=4 with no pop sets overflow_err=1 and that tag never appears.
- 3 entries queued in each FIFO, flush pulsed -> next cycle cdb_valid=0, both FIFOs empty, src_full=0. A push made in the flush cycle never appears.
- rdy_in low for 3 cycles with entries queued -> CDB outputs, counts and rr_ptr are unchanged. Draining resumes on the first cycle rdy_in is high.
- rst_in pulsed low asynchronously mid-drain between clock edges -> outputs go to 0 immediately; no stale broadcast after release.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared constants and helpers for the CDB arbiter
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

package cdb_arbiter_pkg;

   // Fixed source slots; further producers take indices 2 and 3
   localparam int CDB_SRC_ALU        = 0;
   localparam int CDB_SRC_LSB        = 1;
   localparam int CDB_FIFO_DEPTH_BIT = 2;
   localparam int CDB_ROB_WIDTH_BIT  = `ROB_WIDTH_BIT;

   // Width of a source index, never narrower than one bit
   function automatic int src_bit(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer inputs and CDB broadcast bundle
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_SRC       = 2,
   parameter int ROB_WIDTH_BIT = CDB_ROB_WIDTH_BIT
);
   localparam int SRC_BIT = src_bit(NUM_SRC);

   logic [NUM_SRC-1:0]               src_valid;
   logic [NUM_SRC*ROB_WIDTH_BIT-1:0] src_rob_id;
   logic [NUM_SRC*32-1:0]            src_value;
   logic [NUM_SRC-1:0]               src_full;
   logic                             cdb_valid;
   logic [ROB_WIDTH_BIT-1:0]         cdb_rob_id;
   logic [31:0]                      cdb_value;
   logic [SRC_BIT-1:0]               cdb_src;
   logic                             overflow_err;

   modport master (
      input  src_valid, src_rob_id, src_value,
      output src_full, cdb_valid, cdb_rob_id, cdb_value, cdb_src, overflow_err
   );

   modport slave (
      output src_valid, src_rob_id, src_value,
      input  src_full, cdb_valid, cdb_rob_id, cdb_value, cdb_src, overflow_err
   );
endinterface

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-source result FIFO feeding the CDB arbiter
module cdb_src_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int DEPTH_BIT = CDB_FIFO_DEPTH_BIT,
   parameter int DATA_W    = CDB_ROB_WIDTH_BIT + 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic [DEPTH_BIT:0] count_o,
   output logic              empty_o,
   output logic              full_o
);
   localparam int DEPTH = 1 << DEPTH_BIT;

   logic [DATA_W-1:0]    mem_q [DEPTH];
   logic [DEPTH_BIT-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [DEPTH_BIT:0]   cnt_q, cnt_d;
   logic                 do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (DEPTH_BIT+1)'(DEPTH));
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_q];

   // A push into a full FIFO is still taken when the same edge pops it
   always_comb begin
      do_pop  = pop_i & ~empty_o;
      do_push = push_i & (~full_o | do_pop);
      wr_d    = do_push ? wr_q + 1'b1 : wr_q;
      rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
      cnt_d   = cnt_q;
      if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
      if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
   end

   // Pointer and occupancy state; flush empties without touching storage
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage; contents are only meaningful behind cnt_q
   always_ff @(posedge clk_in) begin
      if (do_push && !flush_i) mem_q[wr_q] <= data_i;
   end
endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter; CDB_BYPASS_EN adds same-cycle bypass
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_SRC        = 2,
   parameter int FIFO_DEPTH_BIT = CDB_FIFO_DEPTH_BIT,
   parameter int ROB_WIDTH_BIT  = CDB_ROB_WIDTH_BIT
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          rdy_in,
   input  logic          flush,
   cdb_arbiter_if.master bus
);
   localparam int SRC_BIT = src_bit(NUM_SRC);
   localparam int DEPTH   = 1 << FIFO_DEPTH_BIT;
   localparam int DATA_W  = ROB_WIDTH_BIT + 32;

   logic [NUM_SRC-1:0]      push, pop, empty, full, elig;
   logic [DATA_W-1:0]       in_data  [NUM_SRC];
   logic [DATA_W-1:0]       fifo_out [NUM_SRC];
   logic [FIFO_DEPTH_BIT:0] count    [NUM_SRC];
   logic [DATA_W-1:0]       sel_data;
   logic [SRC_BIT-1:0]      grant, rr_q, rr_d;
   logic                    grant_vld, fifo_flush, ovf_hit;

   logic                     cdb_valid_q;
   logic [ROB_WIDTH_BIT-1:0] cdb_rob_id_q;
   logic [31:0]              cdb_value_q;
   logic [SRC_BIT-1:0]       cdb_src_q;
   logic                     overflow_q;

   assign fifo_flush = rdy_in & flush;

   genvar k;
   generate
      for (k = 0; k < NUM_SRC; k++) begin : g_src
         assign in_data[k] = {bus.src_rob_id[k*ROB_WIDTH_BIT +: ROB_WIDTH_BIT],
                              bus.src_value[k*32 +: 32]};
         assign bus.src_full[k] = (count[k] >= (FIFO_DEPTH_BIT+1)'(DEPTH-1));

         cdb_src_fifo #(.DEPTH_BIT(FIFO_DEPTH_BIT), .DATA_W(DATA_W)) u_fifo (
            .clk_in  (clk_in),
            .rst_in  (rst_in),
            .push_i  (push[k]),
            .pop_i   (pop[k]),
            .flush_i (fifo_flush),
            .data_i  (in_data[k]),
            .data_o  (fifo_out[k]),
            .count_o (count[k]),
            .empty_o (empty[k]),
            .full_o  (full[k])
         );
      end
   endgenerate

   // A source competes when its FIFO holds a result (or, with bypass, a fresh pulse arrives)
   always_comb begin
      elig = ~empty;
`ifdef CDB_BYPASS_EN
      elig = elig | (empty & bus.src_valid);
`endif
   end

   // Round-robin scan from rr_q; scanning backwards lets the nearest source win
   always_comb begin
      int idx;
      grant_vld = 1'b0;
      grant     = '0;
      idx       = 0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         idx = (int'(rr_q) + i) % NUM_SRC;
         if (elig[SRC_BIT'(idx)]) begin
            grant_vld = 1'b1;
            grant     = SRC_BIT'(idx);
         end
      end
      rr_d = grant_vld ? SRC_BIT'((int'(grant) + 1) % NUM_SRC) : rr_q;
   end

   // Push/pop steering and the value headed for the CDB register
   always_comb begin
      push     = '0;
      pop      = '0;
      sel_data = '0;
      if (rdy_in && !flush) begin
         push = bus.src_valid;
         if (grant_vld) begin
            sel_data = fifo_out[grant];
            pop[grant] = 1'b1;
`ifdef CDB_BYPASS_EN
            if (empty[grant]) begin
               sel_data    = in_data[grant];
               pop[grant]  = 1'b0;
               push[grant] = 1'b0;
            end
`endif
         end
      end
      ovf_hit = |(push & full & ~pop);
   end

   // Registered broadcast, round-robin pointer and sticky overflow flag
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cdb_valid_q  <= 1'b0;
         cdb_rob_id_q <= '0;
         cdb_value_q  <= '0;
         cdb_src_q    <= '0;
         rr_q         <= '0;
         overflow_q   <= 1'b0;
      end else if (rdy_in) begin
         if (flush) begin
            cdb_valid_q <= 1'b0;
         end else begin
            cdb_valid_q <= grant_vld;
            if (grant_vld) begin
               cdb_rob_id_q <= sel_data[DATA_W-1:32];
               cdb_value_q  <= sel_data[31:0];
               cdb_src_q    <= grant;
            end
            rr_q <= rr_d;
            if (ovf_hit) overflow_q <= 1'b1;
         end
      end
   end

   assign bus.cdb_valid    = cdb_valid_q;
   assign bus.cdb_rob_id   = cdb_rob_id_q;
   assign bus.cdb_value    = cdb_value_q;
   assign bus.cdb_src      = cdb_src_q;
   assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter (honours CDB_BYPASS_EN)
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N     = 2;
   localparam int RW    = CDB_ROB_WIDTH_BIT;
   localparam int DEPTH = 1 << CDB_FIFO_DEPTH_BIT;
`ifdef CDB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [RW-1:0] tag;
      logic [31:0]   val;
   } item_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rdy   = 1'b1;
   logic fl    = 1'b0;

   cdb_arbiter_if #(.NUM_SRC(N), .ROB_WIDTH_BIT(RW)) bus ();

   cdb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH_BIT(CDB_FIFO_DEPTH_BIT), .ROB_WIDTH_BIT(RW)) dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .rdy_in (rdy),
      .flush  (fl),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   item_t          q [N][$];
   int             rr;
   bit             m_valid;
   item_t          m_item;
   int             m_src;
   bit             m_ovf;
   logic [N-1:0]   v_in;
   item_t          in_item [N];
   int             checks   = 0;
   int             failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N; k++) q[k].delete();
      rr = 0; m_valid = 0; m_item = '0; m_src = 0; m_ovf = 0;
   endtask

   // One clock edge of the arbiter's contract, applied to the input vectors of that cycle
   task automatic model_edge();
      bit consumed [N];
      int g;
      if (!rdy) return;
      if (fl) begin
         for (int k = 0; k < N; k++) q[k].delete();
         m_valid = 0;
         return;
      end
      for (int k = 0; k < N; k++) consumed[k] = 0;
      g = -1;
      for (int i = 0; i < N; i++) begin
         int s;
         bit e;
         s = (rr + i) % N;
         e = q[s].size() > 0;
         if (BYP && v_in[s]) e = 1;
         if (e && g < 0) g = s;
      end
      if (g >= 0) begin
         if (q[g].size() > 0) m_item = q[g].pop_front();
         else begin
            m_item = in_item[g];
            consumed[g] = 1;
         end
         m_valid = 1;
         m_src   = g;
         rr      = (g + 1) % N;
      end else begin
         m_valid = 0;
      end
      for (int k = 0; k < N; k++) begin
         if (v_in[k] && !consumed[k]) begin
            if (q[k].size() < DEPTH) q[k].push_back(in_item[k]);
            else m_ovf = 1;
         end
      end
   endtask

   task automatic check_outputs();
      check("cdb_valid", bus.cdb_valid, m_valid);
      if (m_valid) begin
         check("cdb_rob_id", bus.cdb_rob_id, m_item.tag);
         check("cdb_value", bus.cdb_value, m_item.val);
         check("cdb_src", bus.cdb_src, m_src);
      end
      for (int k = 0; k < N; k++)
         check($sformatf("src_full[%0d]", k), bus.src_full[k], q[k].size() >= DEPTH - 1);
      check("overflow_err", bus.overflow_err, m_ovf);
   endtask

   task automatic drive();
      bus.src_valid = v_in;
      for (int k = 0; k < N; k++) begin
         bus.src_rob_id[k*RW +: RW] = in_item[k].tag;
         bus.src_value[k*32 +: 32]  = in_item[k].val;
      end
   endtask

   // Called just after a falling edge: apply inputs, clock once, check at the next falling edge
   task automatic step();
      drive();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic set_in(input logic [N-1:0] v, input int t0, input int t1);
      v_in = v;
      in_item[0].tag = RW'(t0);
      in_item[0].val = $urandom;
      in_item[1].tag = RW'(t1);
      in_item[1].val = $urandom;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         set_in('0, 0, 0);
         step();
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, bus.cdb_valid, 0);
      check({tag, "_rob"}, bus.cdb_rob_id, 0);
      check({tag, "_value"}, bus.cdb_value, 0);
      check({tag, "_src"}, bus.cdb_src, 0);
      check({tag, "_full"}, bus.src_full, 0);
      check({tag, "_ovf"}, bus.overflow_err, 0);
   endtask

   initial begin
      model_reset();
      set_in('0, 0, 0);
      drive();
      @(negedge clk);
      @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // Single result from the ALU slot: tag 3, value 0x11
      set_in(2'b01, 3, 0);
      in_item[CDB_SRC_ALU].val = 32'h11;
      step();
      check("lat_cyc1_valid", bus.cdb_valid, BYP);
      set_in('0, 0, 0);
      step();
      check("lat_cyc2_valid", bus.cdb_valid, !BYP);
      if (!BYP) begin
         check("lat_tag", bus.cdb_rob_id, 3);
         check("lat_value", bus.cdb_value, 32'h11);
         check("lat_src", bus.cdb_src, CDB_SRC_ALU);
      end
      idle(2);
      check("lat_after_valid", bus.cdb_valid, 0);

      // Both sources push four back-to-back results
      for (int i = 0; i < 4; i++) begin
         set_in(2'b11, i, 8 + i);
         step();
      end
      idle(6);

      // Sustained pushing on both sources until the LSB FIFO overflows
      for (int i = 0; i < 10; i++) begin
         set_in(2'b11, i, 4 + i);
         step();
      end
      check("ovf_sticky", bus.overflow_err, 1);
      idle(2);

      // Asynchronous reset between clock edges while results are still draining
      set_in('0, 0, 0);
      drive();
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);

      // Flush with entries queued; pushes in the flush cycle are dropped
      for (int i = 0; i < 4; i++) begin
         set_in(2'b11, i, 8 + i);
         step();
      end
      fl = 1'b1;
      set_in(2'b11, 14, 15);
      step();
      fl = 1'b0;
      check("flush_valid", bus.cdb_valid, 0);
      check("flush_full", bus.src_full, 0);
      idle(4);

      // Global pause with entries queued, then resume
      for (int i = 0; i < 3; i++) begin
         set_in(2'b11, i, 8 + i);
         step();
      end
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(N'($urandom), $urandom, $urandom);
         step();
      end
      rdy = 1'b1;
      idle(6);

      // Randomized traffic with occasional pauses and flushes
      for (int i = 0; i < 400; i++) begin
         set_in(N'($urandom), $urandom, $urandom);
         rdy = ($urandom_range(0, 7) != 0);
         fl  = ($urandom_range(0, 24) == 0);
         step();
      end
      rdy = 1'b1;
      fl  = 1'b0;
      idle(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
